// File: rtl/pipe_scroller.sv
// Scrolling pipe field: COLS x ROWS bit grid shifted left one column per accepted step, new pipe spawned every SPAWN_PERIOD steps.
// Latency: grid, score and score_pulse all update on the clock edge that samples an accepted step (visible one cycle later).
// Backpressure: none; steps arriving while paused, idle or clearing are dropped, never queued.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   step         one-cycle pipe-rate tick; one column shift per accepted pulse
//   pause        freezes grid, spawn counter, score, LFSR and state (start/clear still honoured)
//   start        IDLE -> RUN
//   clear        synchronous return to IDLE with empty field and zero score (highest priority)
//   grid         column c at bits [c*ROWS +: ROWS], bit 0 = top row, 1 = pipe pixel
//   running      high while in RUN
//   score_pulse  one-cycle registered pulse as a pipe passes BIRD_COL
//   score        saturating count of pipes passed
module pipe_scroller #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int GAP_H        = 4,
    parameter int SPAWN_PERIOD = 8,
    parameter int BIRD_COL     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 pause,
    input  logic                 start,
    input  logic                 clear,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 running,
    output logic                 score_pulse,
    output logic [7:0]           score
);

    // Gap top row is drawn from 1..ROWS-GAP_H-1 so rows 0 and ROWS-1 stay solid.
    localparam int GAP_MOD = ROWS - GAP_H - 1;
    localparam int SCW     = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [SCW-1:0] SPAWN_LAST = SCW'(SPAWN_PERIOD - 1);
    localparam logic [7:0]     LFSR_SEED  = 8'hA5;
    localparam logic [7:0]     SCORE_MAX  = 8'hFF;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [COLS*ROWS-1:0] grid_q, grid_d;
    logic [SCW-1:0]       spawn_cnt_q, spawn_cnt_d;
    logic [7:0]           score_q, score_d;
    logic                 score_pulse_q, score_pulse_d;
    logic [7:0]           lfsr_q, lfsr_d;

    logic                 step_acc;
    logic                 bird_hit;
    logic                 lfsr_fb;
    logic [7:0]           gap_top;
    logic [ROWS-1:0]      pipe_col;
    logic [ROWS-1:0]      new_col;

    assign step_acc = step && (state_q == S_RUN) && !pause && !clear;

    // Scoring looks at the bird column before this step's shift.
    assign bird_hit = (grid_q[BIRD_COL*ROWS +: ROWS] != '0);

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, so the non-zero seed never reaches 0).
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    assign gap_top = (lfsr_q % 8'(GAP_MOD)) + 8'd1;

    always_comb begin
        pipe_col = '1;
        for (int r = 0; r < ROWS; r++) begin
            if ((r >= int'(gap_top)) && (r < int'(gap_top) + GAP_H)) begin
                pipe_col[r] = 1'b0;
            end
        end
    end

    assign new_col = (spawn_cnt_q == '0) ? pipe_col : '0;

    always_comb begin
        state_d       = state_q;
        grid_d        = grid_q;
        spawn_cnt_d   = spawn_cnt_q;
        score_d       = score_q;
        score_pulse_d = 1'b0;
        lfsr_d        = lfsr_q;

        // The LFSR free-runs in both states so gap positions depend on start timing.
        if (!pause) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end

        if (clear) begin
            state_d     = S_IDLE;
            grid_d      = '0;
            score_d     = '0;
            spawn_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            grid_d = '0;
            if (start) begin
                state_d     = S_RUN;
                spawn_cnt_d = '0;
            end
        end else if (step_acc) begin
            // Column i takes column i+1; column 0 falls off the left edge.
            grid_d      = {new_col, grid_q[COLS*ROWS-1:ROWS]};
            spawn_cnt_d = (spawn_cnt_q == SPAWN_LAST) ? '0 : spawn_cnt_q + 1'b1;
            if (bird_hit) begin
                score_pulse_d = 1'b1;
                if (score_q != SCORE_MAX) begin
                    score_d = score_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            grid_q        <= '0;
            spawn_cnt_q   <= '0;
            score_q       <= '0;
            score_pulse_q <= 1'b0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            state_q       <= state_d;
            grid_q        <= grid_d;
            spawn_cnt_q   <= spawn_cnt_d;
            score_q       <= score_d;
            score_pulse_q <= score_pulse_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign grid        = grid_q;
    assign running     = (state_q == S_RUN);
    assign score_pulse = score_pulse_q;
    assign score       = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: directed scenarios followed by randomized traffic, all scored against a field model.
// Latency: expectations are pushed when inputs are driven and popped one clock edge later by the monitor.
// Backpressure: not applicable; the monitor checks every cycle that has a pending expectation.
module tb_pipe_scroller;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int GAP_H = 4;
    localparam int SP    = 8;
    localparam int BIRD  = 3;
    localparam int GW    = COLS * ROWS;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          step  = 1'b0;
    logic          pause = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [GW-1:0] grid;
    logic          running;
    logic          score_pulse;
    logic [7:0]    score;

    pipe_scroller #(
        .ROWS(ROWS), .COLS(COLS), .GAP_H(GAP_H), .SPAWN_PERIOD(SP), .BIRD_COL(BIRD)
    ) dut (
        .clk(clk), .reset(reset), .step(step), .pause(pause), .start(start), .clear(clear),
        .grid(grid), .running(running), .score_pulse(score_pulse), .score(score)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the field as an array of columns ----------------
    typedef struct {
        logic [GW-1:0] g;
        logic          run;
        logic [7:0]    sc;
        logic          sp;
    } exp_t;

    exp_t            exp_q[$];
    logic [ROWS-1:0] m_col[COLS];
    bit              m_run;
    int              m_score;
    int              m_since;    // accepted steps since the last spawn, modulo SP
    bit              m_pulse;
    logic [7:0]      m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [ROWS-1:0] pipe_of(input logic [7:0] v);
        logic [ROWS-1:0] c;
        int g;
        c = '1;
        g = (int'(v) % (ROWS - GAP_H - 1)) + 1;
        for (int r = g; r < g + GAP_H; r++) c[r] = 1'b0;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < COLS; i++) m_col[i] = '0;
        m_run = 0; m_score = 0; m_since = 0; m_pulse = 0; m_lfsr = 8'hA5;
    endtask

    task automatic model_update(input bit st, input bit ps, input bit sr, input bit cl, input bit rs);
        bit acc;
        if (!rs) begin
            model_reset();
            return;
        end
        acc     = st && m_run && !ps && !cl;
        m_pulse = acc && (m_col[BIRD] != '0);
        if (acc) begin
            for (int i = 0; i < COLS - 1; i++) m_col[i] = m_col[i+1];
            m_col[COLS-1] = (m_since == 0) ? pipe_of(m_lfsr) : '0;
            m_since = (m_since + 1) % SP;
            if (m_pulse && m_score < 255) m_score++;
        end
        if (cl) begin
            for (int i = 0; i < COLS; i++) m_col[i] = '0;
            m_run = 0; m_score = 0; m_since = 0;
        end else if (!m_run && sr) begin
            m_run = 1; m_since = 0;
        end
        if (!ps) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < COLS; i++) e.g[i*ROWS +: ROWS] = m_col[i];
        e.run = m_run;
        e.sc  = 8'(m_score);
        e.sp  = m_pulse;
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: drive at the falling edge, predict the state after the next rising edge.
    task automatic cyc(input bit st, input bit ps, input bit sr, input bit cl, input bit rs);
        @(negedge clk);
        step = st; pause = ps; start = sr; clear = cl; reset = rs;
        model_update(st, ps, sr, cl, rs);
        push_exp();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grid",        GW'(grid),        GW'(e.g));
                chk("running",     GW'(running),     GW'(e.run));
                chk("score",       GW'(score),       GW'(e.sc));
                chk("score_pulse", GW'(score_pulse), GW'(e.sp));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [ROWS-1:0] c15;
        bit              shape_ok;

        model_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Start, then a first step spawns a pipe at the right edge.
        cyc(0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        c15 = grid[(COLS-1)*ROWS +: ROWS];
        shape_ok = 0;
        for (int k = 1; k <= ROWS - GAP_H - 1; k++) begin
            logic [ROWS-1:0] hole;
            hole = ROWS'(16'hF) << k;
            if (c15 == ~hole) shape_ok = 1;
        end
        chk("first_pipe_shape", GW'(shape_ok), GW'(1));

        // Thirteen more back-to-back steps: the first pipe reaches the bird column on step 14.
        for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("score_after_14", GW'(score), GW'(1));

        // Paused steps are dropped; one unpaused step shifts once.
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1);

        // clear wins over a simultaneous step; later steps without start do nothing.
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
        chk("grid_after_clear", GW'(grid), GW'(0));

        // start together with a step in IDLE only enters RUN; then run until score saturates.
        cyc(1, 0, 1, 0, 1);
        for (int i = 0; i < 2070; i++) cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("score_saturated", GW'(score), GW'(255));

        // Mid-run asynchronous reset clears outputs before the next rising edge.
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("grid_nonzero_before_reset", GW'(grid != '0), GW'(1));
        @(negedge clk);
        step = 0; pause = 0; start = 0; clear = 0; reset = 0;
        model_update(0, 0, 0, 0, 0);
        push_exp();
        #2;
        chk("async_grid",    GW'(grid),    GW'(0));
        chk("async_score",   GW'(score),   GW'(0));
        chk("async_running", GW'(running), GW'(0));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit st, ps, sr, cl, rs;
            st = ($urandom_range(0, 3) != 0);
            ps = ($urandom_range(0, 9) == 0);
            sr = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 999) != 0);
            cyc(st, ps, sr, cl, rs);
        end

        cyc(0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", GW'(exp_q.size()), GW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Downstream consumer of the pipe-rate tick: holds the on-screen pipe field as a COLS x ROWS bit grid.
- Shifts the grid one column left per accepted step pulse and spawns a new pipe column with a pseudo-random gap every SPAWN_PERIOD steps.
- Emits a one-cycle score pulse plus a saturating score count as each pipe passes the bird column.
- Output grid feeds the LED-matrix driver and the collision checker.

Parameters:
- ROWS, 16, rows per column (bit 0 = top row).
- COLS, 16, columns in the field (column 0 = leftmost, COLS-1 = spawn edge).
- GAP_H, 4, height of the opening in each pipe, in rows.
- SPAWN_PERIOD, 8, accepted steps between pipe spawns (>=1).
- BIRD_COL, 3, column the bird occupies; scoring reference.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle tick from the pipe-rate counter; one column shift per pulse.
- pause  in  1  freezes all state while high.
- start  in  1  IDLE -> RUN.
- clear  in  1  synchronous return to IDLE with empty field and zero score.
- grid  out  COLS*ROWS  column c occupies bits [c*ROWS +: ROWS]; 1 = pipe pixel.
- running  out  1  high in RUN.
- score_pulse  out  1  one-cycle, registered.
- score  out  8  pipes passed, saturates at 255.

Behaviour:
- Reset (reset low, async): grid = 0, state = IDLE, spawn_cnt = 0, score = 0, score_pulse = 0, LFSR = 8'hA5. All outputs are 0 during reset.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clk while not paused, in both IDLE and RUN.
  - Never reaches 0 from the seed.
- Gap row:
  - gap_top = (lfsr mod (ROWS-GAP_H-1)) + 1; range 1..ROWS-GAP_H-1 (1..11 at defaults).
  - Pipe column = all ones except rows gap_top .. gap_top+GAP_H-1.
  - Rows 0 and ROWS-1 are always set.
- States: IDLE, RUN.
  - IDLE: grid held at 0, step ignored, start -> RUN next cycle with spawn_cnt = 0.
  - RUN: start ignored.
  - clear, in either state: next cycle is IDLE, grid = 0, score = 0, spawn_cnt = 0. LFSR is not reseeded.
- Accepted step = step && RUN && !pause && !clear. On an accepted step, in a single clock edge:
  - col[i] <= col[i+1] for i = 0..COLS-2; column 0 is discarded.
  - col[COLS-1] <= pipe column if spawn_cnt == 0, else 0.
  - spawn_cnt <= (spawn_cnt == SPAWN_PERIOD-1) ? 0 : spawn_cnt + 1.
  - If the pre-shift col[BIRD_COL] != 0: score_pulse = 1 for exactly the next cycle, and score increments unless it is already 255.
- Latency: grid reflects the shift one cycle after the step edge. score_pulse and score update on the same edge.
- score_pulse is 0 in every cycle without an accepted scoring step.
- pause high:
  - grid, spawn_cnt, score, LFSR and state all hold.
  - step pulses are dropped, not queued.
  - start and clear are still honoured; clear has priority over everything.
- Simultaneous events:
  - clear + step: clear wins, no shift, no score.
  - start + step in IDLE: enter RUN only; that step is not shifted.
  - Back-to-back step on consecutive cycles: each pulse produces one shift.
- Reset asserted mid-run: immediate return to reset values; no partial shift.

Test Plan:
- Reset low, then high; pulse start; 1 step -> running=1; grid column 15 has bits 0 and 15 set with exactly 4 contiguous zeros in rows 1..14; columns 0..14 = 0; score=0.
- From that state, 13 more steps (14 total) -> 14th step asserts score_pulse for exactly 1 cycle, score=1. The next spawned pipe is in column 15 after step 9, and column 7 holds the first pipe after step 9.
- pause=1 and 5 steps issued -> grid, score and LFSR unchanged. pause=0, 1 step -> exactly one shift.
- clear and step asserted in the same cycle during RUN -> next cycle grid=0, score=0, running=0, score_pulse=0. Further steps without start leave grid=0.
- Force score to 255 by running long; another scoring step -> score_pulse=1, score stays 255.
- Drive reset low mid-run with a non-zero grid -> grid=0, score=0, running=0 asynchronously, before the next clk edge.
